// File: rtl/apb_pkg.sv
// Shared types and default sizing for the APB master/slave subsystem.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_e;

    localparam int APB_ADDRESS  = 8;
    localparam int APB_DATA     = 8;
    localparam int APB_LOCATION = 64;

endpackage

// File: rtl/apb_if.sv
// Internal APB bus between master and slave; PSLVERR exists only when APB_SLVERR_EN is defined.
interface apb_if #(
    parameter int ADDRESS = 8,
    parameter int DATA    = 8
);
    logic               psel;
    logic               penable;
    logic               pwrite;
    logic [ADDRESS-1:0] paddr;
    logic [DATA-1:0]    pwdata;
    logic [DATA-1:0]    prdata;
    logic               pready;
`ifdef APB_SLVERR_EN
    logic               pslverr;
`endif

    modport master (
`ifdef APB_SLVERR_EN
        input  pslverr,
`endif
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready
    );

    modport slave (
`ifdef APB_SLVERR_EN
        output pslverr,
`endif
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready
    );
endinterface

// File: rtl/apb_master.sv
// APB master: IDLE/SETUP/ACCESS FSM with registered bus outputs and read-data register.
// With APB_SLVERR_EN defined, also registers PSLVERR at each completion on apb_slverr.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDRESS = APB_ADDRESS,
    parameter int DATA    = APB_DATA
) (
    input  logic               PCLK,
    input  logic               PRESETn,
    input  logic               transfer,
    input  logic               READ_WRITE,
    input  logic [ADDRESS-1:0] apb_write_paddr,
    input  logic [ADDRESS-1:0] apb_read_paddr,
    input  logic [DATA-1:0]    apb_write_data,
    apb_if.master              bus,
    output logic [DATA-1:0]    apb_read_data_out
`ifdef APB_SLVERR_EN
    ,
    output logic               apb_slverr
`endif
);

    apb_state_e         state;
    logic [ADDRESS-1:0] req_addr;

    assign req_addr = READ_WRITE ? apb_write_paddr : apb_read_paddr;

    // NOTE: all state here is registered with non-blocking assignments so every
    // flop samples pre-edge values and block ordering cannot change behaviour.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state             <= IDLE;
            bus.psel          <= 1'b0;
            bus.penable       <= 1'b0;
            bus.pwrite        <= 1'b0;
            bus.paddr         <= '0;
            bus.pwdata        <= '0;
            apb_read_data_out <= '0;
`ifdef APB_SLVERR_EN
            apb_slverr        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (transfer) begin
                        state       <= SETUP;
                        bus.psel    <= 1'b1;
                        bus.penable <= 1'b0;
                        bus.pwrite  <= READ_WRITE;
                        bus.paddr   <= req_addr;
                        bus.pwdata  <= apb_write_data;
                    end
                end
                SETUP: begin
                    state       <= ACCESS;
                    bus.penable <= 1'b1;
                end
                ACCESS: begin
                    if (bus.pready) begin
                        if (!bus.pwrite) apb_read_data_out <= bus.prdata;
`ifdef APB_SLVERR_EN
                        apb_slverr <= bus.pslverr;
`endif
                        bus.penable <= 1'b0;
                        // Back-to-back: go straight to SETUP, recapturing the request.
                        if (transfer) begin
                            state      <= SETUP;
                            bus.pwrite <= READ_WRITE;
                            bus.paddr  <= req_addr;
                            bus.pwdata <= apb_write_data;
                        end else begin
                            state    <= IDLE;
                            bus.psel <= 1'b0;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    bus.psel    <= 1'b0;
                    bus.penable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/apb_slave_mem.sv
// Zero-wait-state APB slave memory. Default build wraps addresses modulo LOCATION;
// with APB_SLVERR_EN out-of-range accesses raise PSLVERR, drop writes and read 0.
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int ADDRESS  = APB_ADDRESS,
    parameter int DATA     = APB_DATA,
    parameter int LOCATION = APB_LOCATION
) (
    input logic  PCLK,
    input logic  PRESETn,
    apb_if.slave bus
);

    localparam int IDX_W = $clog2(LOCATION);

    logic [DATA-1:0]  mem [LOCATION];
    logic [IDX_W-1:0] idx;
    logic             addr_ok;

    assign idx        = bus.paddr[IDX_W-1:0];
    assign bus.pready = 1'b1;

`ifdef APB_SLVERR_EN
    assign addr_ok     = (32'(bus.paddr) < 32'(LOCATION));
    assign bus.pslverr = bus.psel & bus.penable & ~addr_ok;
`else
    assign addr_ok = 1'b1;
`endif

    // NOTE: default assignment first so no path through the block leaves prdata
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        bus.prdata = '0;
        if (bus.psel && !bus.pwrite && addr_ok) bus.prdata = mem[idx];
    end

    // NOTE: this memory is deliberately reset word-by-word because a cleared
    // memory is part of the block's reset state; that rules out a plain RAM macro.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            for (int i = 0; i < LOCATION; i++) mem[i] <= '0;
        end else if (bus.psel && bus.penable && bus.pwrite && bus.pready && addr_ok) begin
            mem[idx] <= bus.pwdata;
        end
    end

endmodule

// File: rtl/apb_master_slave_top.sv
// APB subsystem top: wires apb_master to apb_slave_mem over an internal apb_if.
// Optional APB_SLVERR_EN adds slave error signalling and the apb_slverr output.
module apb_master_slave_top
    import apb_pkg::*;
#(
    parameter int ADDRESS  = APB_ADDRESS,
    parameter int DATA     = APB_DATA,
    parameter int LOCATION = APB_LOCATION
) (
    input  logic               PCLK,
    input  logic               PRESETn,
    input  logic               transfer,
    input  logic               READ_WRITE,
    input  logic [ADDRESS-1:0] apb_write_paddr,
    input  logic [ADDRESS-1:0] apb_read_paddr,
    input  logic [DATA-1:0]    apb_write_data,
    output logic [DATA-1:0]    apb_read_data_out
`ifdef APB_SLVERR_EN
    ,
    output logic               apb_slverr
`endif
);

    apb_if #(.ADDRESS(ADDRESS), .DATA(DATA)) bus ();

    apb_master #(.ADDRESS(ADDRESS), .DATA(DATA)) u_master (
        .PCLK              (PCLK),
        .PRESETn           (PRESETn),
        .transfer          (transfer),
        .READ_WRITE        (READ_WRITE),
        .apb_write_paddr   (apb_write_paddr),
        .apb_read_paddr    (apb_read_paddr),
        .apb_write_data    (apb_write_data),
        .bus               (bus),
        .apb_read_data_out (apb_read_data_out)
`ifdef APB_SLVERR_EN
        ,
        .apb_slverr        (apb_slverr)
`endif
    );

    apb_slave_mem #(.ADDRESS(ADDRESS), .DATA(DATA), .LOCATION(LOCATION)) u_slave (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus)
    );

endmodule

// File: tb/tb_apb_master_slave_top.sv
// Directed bench for apb_master_slave_top; bus and memory observed hierarchically.
// Expectations for address 66 depend on APB_SLVERR_EN.
module tb_apb_master_slave_top;

    localparam int ADDRESS  = 8;
    localparam int DATA     = 8;
    localparam int LOCATION = 64;

    logic               PCLK = 1'b0;
    logic               PRESETn;
    logic               transfer;
    logic               READ_WRITE;
    logic [ADDRESS-1:0] apb_write_paddr;
    logic [ADDRESS-1:0] apb_read_paddr;
    logic [DATA-1:0]    apb_write_data;
    logic [DATA-1:0]    apb_read_data_out;
`ifdef APB_SLVERR_EN
    logic               apb_slverr;
`endif

    int passed = 0;
    int total  = 0;

    always #5 PCLK = ~PCLK;

    apb_master_slave_top #(.ADDRESS(ADDRESS), .DATA(DATA), .LOCATION(LOCATION)) dut (
        .PCLK              (PCLK),
        .PRESETn           (PRESETn),
        .transfer          (transfer),
        .READ_WRITE        (READ_WRITE),
        .apb_write_paddr   (apb_write_paddr),
        .apb_read_paddr    (apb_read_paddr),
        .apb_write_data    (apb_write_data),
        .apb_read_data_out (apb_read_data_out)
`ifdef APB_SLVERR_EN
        ,
        .apb_slverr        (apb_slverr)
`endif
    );

    // Probe copy of the internal bus, driven from the DUT hierarchy.
    apb_if #(.ADDRESS(ADDRESS), .DATA(DATA)) mon ();
    assign mon.psel    = dut.bus.psel;
    assign mon.penable = dut.bus.penable;
    assign mon.pwrite  = dut.bus.pwrite;
    assign mon.paddr   = dut.bus.paddr;
    assign mon.pwdata  = dut.bus.pwdata;
    assign mon.prdata  = dut.bus.prdata;
    assign mon.pready  = dut.bus.pready;
`ifdef APB_SLVERR_EN
    assign mon.pslverr = dut.bus.pslverr;
`endif

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    initial begin
        PRESETn         = 1'b0;
        transfer        = 1'b0;
        READ_WRITE      = 1'b0;
        apb_write_paddr = '0;
        apb_read_paddr  = '0;
        apb_write_data  = '0;
        tick();
        tick();
        check("rst_psel",    32'(mon.psel), 0);
        check("rst_penable", 32'(mon.penable), 0);
        check("rst_paddr",   32'(mon.paddr), 0);
        check("rst_rdata",   32'(apb_read_data_out), 0);
        check("rst_mem2",    32'(dut.u_slave.mem[2]), 0);
        PRESETn = 1'b1;

        // Write 6 -> 2, held for two back-to-back transactions.
        transfer        = 1'b1;
        READ_WRITE      = 1'b1;
        apb_write_paddr = 8'd2;
        apb_write_data  = 8'd6;
        tick();
        check("w1_setup_psel",    32'(mon.psel), 1);
        check("w1_setup_penable", 32'(mon.penable), 0);
        check("w1_setup_paddr",   32'(mon.paddr), 2);
        check("w1_setup_pwdata",  32'(mon.pwdata), 6);
        tick();
        check("w1_access_psel",    32'(mon.psel), 1);
        check("w1_access_penable", 32'(mon.penable), 1);
        tick();
        check("w1_mem2",        32'(dut.u_slave.mem[2]), 6);
        check("w2_setup_psel",  32'(mon.psel), 1);
        check("w2_setup_pen",   32'(mon.penable), 0);
        tick();
        check("w2_access_pen", 32'(mon.penable), 1);

        // 98 -> 16 captured at the end of this ACCESS.
        apb_write_paddr = 8'd16;
        apb_write_data  = 8'd98;
        tick();
        check("w3_setup_paddr", 32'(mon.paddr), 16);
        // Changes during SETUP must not leak into the in-flight write.
        apb_write_paddr = 8'd15;
        apb_write_data  = 8'd3;
        tick();
        check("w3_access_paddr",  32'(mon.paddr), 16);
        check("w3_access_pwdata", 32'(mon.pwdata), 98);
        tick();
        check("w3_mem16",       32'(dut.u_slave.mem[16]), 98);
        check("w4_setup_paddr", 32'(mon.paddr), 15);
        tick();
        check("w4_access_pen", 32'(mon.penable), 1);
        // Present 63 -> 20 and drop transfer during ACCESS.
        apb_write_paddr = 8'd20;
        apb_write_data  = 8'd63;
        transfer        = 1'b0;
        tick();
        check("w4_mem15",   32'(dut.u_slave.mem[15]), 3);
        check("idle_psel",  32'(mon.psel), 0);
        check("idle_pen",   32'(mon.penable), 0);
        tick();
        check("idle_hold_psel", 32'(mon.psel), 0);
        check("mem20_untouched", 32'(dut.u_slave.mem[20]), 0);

        // Read 15, then a write 10 -> 5 that must not disturb the read data.
        READ_WRITE     = 1'b0;
        apb_read_paddr = 8'd15;
        transfer       = 1'b1;
        tick();
        check("r1_setup_paddr",  32'(mon.paddr), 15);
        check("r1_setup_pwrite", 32'(mon.pwrite), 0);
        check("r1_setup_prdata", 32'(mon.prdata), 3);
        tick();
        check("r1_rdata_pending", 32'(apb_read_data_out), 0);
        READ_WRITE      = 1'b1;
        apb_write_paddr = 8'd5;
        apb_write_data  = 8'd10;
        tick();
        check("r1_rdata",         32'(apb_read_data_out), 3);
        check("w5_setup_pwrite",  32'(mon.pwrite), 1);
        check("w5_setup_paddr",   32'(mon.paddr), 5);
        check("w5_setup_prdata",  32'(mon.prdata), 0);
        tick();
        transfer = 1'b0;
        tick();
        check("w5_mem5",       32'(dut.u_slave.mem[5]), 10);
        check("w5_rdata_hold", 32'(apb_read_data_out), 3);
        check("w5_idle_psel",  32'(mon.psel), 0);

        // Reset asserted during ACCESS of a write to 30.
        apb_write_paddr = 8'd30;
        apb_write_data  = 8'd55;
        transfer        = 1'b1;
        tick();
        tick();
        check("w6_access_pen", 32'(mon.penable), 1);
        PRESETn = 1'b0;
        tick();
        check("rst2_mem30",  32'(dut.u_slave.mem[30]), 0);
        check("rst2_mem2",   32'(dut.u_slave.mem[2]), 0);
        check("rst2_rdata",  32'(apb_read_data_out), 0);
        check("rst2_psel",   32'(mon.psel), 0);
        check("rst2_paddr",  32'(mon.paddr), 0);
        PRESETn  = 1'b1;
        transfer = 1'b0;
        tick();
        check("rst2_idle_psel", 32'(mon.psel), 0);

        // Write 7 -> 66 (aliases to 2, or out of range with error signalling).
        READ_WRITE      = 1'b1;
        apb_write_paddr = 8'd66;
        apb_write_data  = 8'd7;
        transfer        = 1'b1;
        tick();
        check("w7_setup_paddr", 32'(mon.paddr), 66);
        transfer = 1'b0;
        tick();
`ifdef APB_SLVERR_EN
        check("w7_pslverr", 32'(mon.pslverr), 1);
`endif
        tick();
`ifdef APB_SLVERR_EN
        check("w7_mem2_dropped", 32'(dut.u_slave.mem[2]), 0);
        check("w7_slverr",       32'(apb_slverr), 1);
`else
        check("w7_mem2_alias",   32'(dut.u_slave.mem[2]), 7);
`endif

        // Read back 66.
        READ_WRITE     = 1'b0;
        apb_read_paddr = 8'd66;
        transfer       = 1'b1;
        tick();
        transfer = 1'b0;
        tick();
        tick();
`ifdef APB_SLVERR_EN
        check("r66_rdata",  32'(apb_read_data_out), 0);
        check("r66_slverr", 32'(apb_slverr), 1);
`else
        check("r66_rdata",  32'(apb_read_data_out), 7);
`endif
        check("r66_idle_psel", 32'(mon.psel), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
